// File: rtl/rr_write_arbiter_if.sv
// Requester-side bus for the round-robin write arbiter.
interface rr_write_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned N    = 8
);
  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   req;
  logic [NREQ*N-1:0] wdata;
  logic [NREQ-1:0]   ack;
  logic [IDW-1:0]    grant_id;
  logic              busy;
  logic              wr_en;
  logic [N-1:0]      q;

  // Requesting agents drive req/wdata and observe the rest.
  modport master (
    output req, wdata,
    input  ack, grant_id, busy, wr_en, q
  );

  // Arbiter side.
  modport slave (
    input  req, wdata,
    output ack, grant_id, busy, wr_en, q
  );
endinterface

// File: rtl/rr_write_arbiter.sv
// Round-robin write controller owning one shared N-bit register.
// Every write runs IDLE -> WRITE -> HOLD so q stays stable after each update.
module rr_write_arbiter #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned N        = 8,
  parameter int unsigned HOLD_CYC = 2
) (
  input  logic              clk,
  input  logic              rstN,
  rr_write_arbiter_if.slave bus
);
  localparam int unsigned IDW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CNTW      = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam int unsigned HOLD_INIT = (HOLD_CYC == 0) ? 0 : HOLD_CYC - 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t          r_state;
  logic [CNTW-1:0] r_cnt;
  logic [IDW-1:0]  r_last;
  logic [IDW-1:0]  r_grant_id;
  logic [N-1:0]    r_wdata;
  logic [N-1:0]    r_q;
  logic [NREQ-1:0] r_ack;
  logic            r_wr_en;
  logic            r_busy;

  state_t          w_state_nxt;
  logic [CNTW-1:0] w_cnt_nxt;
  logic [IDW-1:0]  w_idx;
  logic [IDW-1:0]  w_pick;
  logic            w_any;
  logic [NREQ-1:0] w_ack_nxt;
  logic            w_wr_en_nxt;
  logic            w_busy_nxt;

  // Round-robin search starting just after the last grantee.
  always_comb begin
    w_idx  = '0;
    w_pick = '0;
    w_any  = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      w_idx = IDW'((32'(r_last) + k) % NREQ);
      if (!w_any && bus.req[w_idx]) begin
        w_pick = w_idx;
        w_any  = 1'b1;
      end
    end
  end

  // State and hold-counter register.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic; HOLD counts down to zero before releasing to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_any) w_state_nxt = S_WRITE;
      end
      S_WRITE: begin
        if (HOLD_CYC == 0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = CNTW'(HOLD_INIT);
        end
      end
      S_HOLD: begin
        if (r_cnt == '0) w_state_nxt = S_IDLE;
        else             w_cnt_nxt   = r_cnt - CNTW'(1);
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode from the next state, so the registered outputs track the state register.
  always_comb begin
    w_ack_nxt   = '0;
    w_wr_en_nxt = 1'b0;
    w_busy_nxt  = (w_state_nxt != S_IDLE);
    if (w_state_nxt == S_WRITE) begin
      w_wr_en_nxt = 1'b1;
      w_ack_nxt   = NREQ'(1) << w_pick;
    end
  end

  // Registered ack / wr_en / busy.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_ack   <= '0;
      r_wr_en <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_ack   <= w_ack_nxt;
      r_wr_en <= w_wr_en_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Grant latch, pointer update and the shared register itself.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_grant_id <= '0;
      r_wdata    <= '0;
      r_last     <= IDW'(NREQ - 1);
      r_q        <= '0;
    end else begin
      if (r_state == S_IDLE && w_any) begin
        r_grant_id <= w_pick;
        r_wdata    <= bus.wdata[32'(w_pick)*N +: N];
      end
      if (r_wr_en) begin
        r_q    <= r_wdata;
        r_last <= r_grant_id;
      end
    end
  end

  assign bus.ack      = r_ack;
  assign bus.wr_en    = r_wr_en;
  assign bus.busy     = r_busy;
  assign bus.grant_id = r_grant_id;
  assign bus.q        = r_q;
endmodule

// File: tb/tb_rr_write_arbiter.sv
// Directed bench for rr_write_arbiter: a vector table plus multi-cycle sequences.
module tb_rr_write_arbiter;
  logic clk  = 1'b0;
  logic rstN = 1'b0;

  always #5 clk = ~clk;

  rr_write_arbiter_if #(.NREQ(4), .N(8)) b  ();
  rr_write_arbiter_if #(.NREQ(4), .N(8)) b0 ();

  rr_write_arbiter #(.NREQ(4), .N(8), .HOLD_CYC(2)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (b)
  );

  rr_write_arbiter #(.NREQ(4), .N(8), .HOLD_CYC(0)) dut0 (
    .clk  (clk),
    .rstN (rstN),
    .bus  (b0)
  );

  typedef struct {
    bit          rst;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  ack;
    logic        wr_en;
    logic        busy;
    logic [1:0]  gid;
    logic [7:0]  q;
  } vec_t;

  vec_t vecs[64];
  int   nv       = 0;
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic add(input bit rst, input logic [3:0] req, input logic [31:0] wd,
                     input logic [3:0] ack, input logic wr, input logic bsy,
                     input logic [1:0] gid, input logic [7:0] q);
    vecs[nv] = '{rst, req, wd, ack, wr, bsy, gid, q};
    nv++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rstN = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstN = 1'b1;
  endtask

  // Bounded wait for the next WRITE cycle on the HOLD_CYC=2 instance.
  task automatic wait_write(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (b.wr_en === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    bit ok;
    int exp_g[4];

    b.req   = '0;
    b.wdata = '0;
    b0.req  = '0;
    b0.wdata = '0;

    // Reset with all requests high, then four-way round robin from reset.
    add(1, 4'hF, 32'h13121110, 4'h0, 0, 0, 0, 8'h00);
    add(0, 4'hF, 32'h13121110, 4'h1, 1, 1, 0, 8'h00);
    add(0, 4'hE, 32'h13121110, 4'h0, 0, 1, 0, 8'h10);
    add(0, 4'hE, 32'h13121110, 4'h0, 0, 1, 0, 8'h10);
    add(0, 4'hE, 32'h13121110, 4'h0, 0, 0, 0, 8'h10);
    add(0, 4'hE, 32'h13121110, 4'h2, 1, 1, 1, 8'h10);
    add(0, 4'hC, 32'h13121110, 4'h0, 0, 1, 1, 8'h11);
    add(0, 4'hC, 32'h13121110, 4'h0, 0, 1, 1, 8'h11);
    add(0, 4'hC, 32'h13121110, 4'h0, 0, 0, 1, 8'h11);
    add(0, 4'hC, 32'h13121110, 4'h4, 1, 1, 2, 8'h11);
    add(0, 4'h8, 32'h13121110, 4'h0, 0, 1, 2, 8'h12);
    add(0, 4'h8, 32'h13121110, 4'h0, 0, 1, 2, 8'h12);
    add(0, 4'h8, 32'h13121110, 4'h0, 0, 0, 2, 8'h12);
    add(0, 4'h8, 32'h13121110, 4'h8, 1, 1, 3, 8'h12);
    add(0, 4'h0, 32'h13121110, 4'h0, 0, 1, 3, 8'h13);
    add(0, 4'h0, 32'h13121110, 4'h0, 0, 1, 3, 8'h13);
    add(0, 4'h0, 32'h13121110, 4'h0, 0, 0, 3, 8'h13);
    // Single request from requester 2; req0 raised during HOLD waits for IDLE.
    add(0, 4'h4, 32'h00A50077, 4'h4, 1, 1, 2, 8'h13);
    add(0, 4'h1, 32'h00A50077, 4'h0, 0, 1, 2, 8'hA5);
    add(0, 4'h1, 32'h00A50077, 4'h0, 0, 1, 2, 8'hA5);
    add(0, 4'h1, 32'h00A50077, 4'h0, 0, 0, 2, 8'hA5);
    add(0, 4'h1, 32'h00A50077, 4'h1, 1, 1, 0, 8'hA5);
    add(0, 4'h0, 32'h00A50077, 4'h0, 0, 1, 0, 8'h77);
    add(0, 4'h0, 32'h00A50077, 4'h0, 0, 1, 0, 8'h77);
    add(0, 4'h0, 32'h00A50077, 4'h0, 0, 0, 0, 8'h77);

    for (int i = 0; i < nv; i++) begin
      b.req   = vecs[i].req;
      b.wdata = vecs[i].wdata;
      if (vecs[i].rst) begin
        rstN = 1'b0;
        #2;
      end else begin
        @(posedge clk);
        #1;
      end
      chk($sformatf("v%0d_ack", i),   32'(b.ack),      32'(vecs[i].ack));
      chk($sformatf("v%0d_wr_en", i), 32'(b.wr_en),    32'(vecs[i].wr_en));
      chk($sformatf("v%0d_busy", i),  32'(b.busy),     32'(vecs[i].busy));
      chk($sformatf("v%0d_gid", i),   32'(b.grant_id), 32'(vecs[i].gid));
      chk($sformatf("v%0d_q", i),     32'(b.q),        32'(vecs[i].q));
      if (vecs[i].rst) begin
        @(negedge clk);
        rstN = 1'b1;
      end
    end

    // Fairness: req0 re-raised after each ack, req3 held high.
    b.req = '0;
    do_reset();
    b.wdata = 32'h33000000;
    b.req   = 4'b1001;
    exp_g   = '{0, 3, 0, 3};
    for (int g = 0; g < 4; g++) begin
      wait_write(ok);
      chk($sformatf("fair%0d_timeout", g), 32'(ok), 32'd1);
      chk($sformatf("fair%0d_gid", g), 32'(b.grant_id), 32'(exp_g[g]));
      chk($sformatf("fair%0d_ack", g), 32'(b.ack), 32'(4'b0001 << exp_g[g]));
      if (b.grant_id == 2'd0) begin
        b.req[0] = 1'b0;
        @(posedge clk);
        #1;
        b.req[0] = 1'b1;
      end
    end

    // Reset during HOLD with req1 pending.
    b.req = '0;
    do_reset();
    b.wdata = 32'h00003C5A;
    b.req   = 4'b0001;
    wait_write(ok);
    chk("rsthold_timeout0", 32'(ok), 32'd1);
    chk("rsthold_gid0", 32'(b.grant_id), 32'd0);
    b.req = 4'b0010;
    @(posedge clk);
    #1;
    chk("rsthold_q5a", 32'(b.q), 32'h5A);
    chk("rsthold_busy", 32'(b.busy), 32'd1);
    #2;
    rstN = 1'b0;
    #1;
    chk("rsthold_q_clr", 32'(b.q), 32'd0);
    chk("rsthold_busy_clr", 32'(b.busy), 32'd0);
    chk("rsthold_ack_clr", 32'(b.ack), 32'd0);
    chk("rsthold_wr_clr", 32'(b.wr_en), 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    #1;
    chk("rsthold_no_stale_ack", 32'(b.ack), 32'd0);
    wait_write(ok);
    chk("rsthold_timeout1", 32'(ok), 32'd1);
    chk("rsthold_gid1", 32'(b.grant_id), 32'd1);
    chk("rsthold_ack1", 32'(b.ack), 32'b0010);
    b.req = '0;
    @(posedge clk);
    #1;
    chk("rsthold_q3c", 32'(b.q), 32'h3C);

    // HOLD_CYC=0 instance: WRITE every other cycle, alternating 0,1.
    b0.req = '0;
    do_reset();
    b0.wdata = 32'h00002120;
    b0.req   = 4'b0011;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("h0_c%0d_wr", k), 32'(b0.wr_en), 32'((k % 2) == 0));
      chk($sformatf("h0_c%0d_busy", k), 32'(b0.busy), 32'((k % 2) == 0));
      if ((k % 2) == 0) begin
        chk($sformatf("h0_c%0d_gid", k), 32'(b0.grant_id), 32'((k / 2) % 2));
        chk($sformatf("h0_c%0d_ack", k), 32'(b0.ack), 32'(1 << ((k / 2) % 2)));
      end else begin
        chk($sformatf("h0_c%0d_ack", k), 32'(b0.ack), 32'd0);
        chk($sformatf("h0_c%0d_q", k), 32'(b0.q), 32'h20 + 32'(((k - 1) / 2) % 2));
      end
    end
    b0.req = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
